// File: rtl/wave_sequence_ctrl.sv
// Playlist sequencer for the waveform generator: drives wave/frequency/amplitude selects
// from manual switches or from a small playlist whose entry changes align to phase wraps.
module wave_sequence_ctrl #(
  parameter int DEPTH       = 8,
  parameter int IDX_W       = 3,
  parameter int DWELL_W     = 24,
  parameter int WRAP_TO     = 1024,
  parameter int SYNC_SWITCH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         man_s0,
  input  logic [2:0]         man_s1,
  input  logic [1:0]         man_s2,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [7:0]         cfg_data,
  input  logic [IDX_W:0]     seq_len,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               loop_en,
  input  logic               start,
  input  logic               stop,
  input  logic               phase_wrap,
  output logic [2:0]         s0,
  output logic [2:0]         s1,
  output logic [1:0]         s2,
  output logic               busy,
  output logic [IDX_W-1:0]   entry_idx,
  output logic               switch_pulse,
  output logic               done
);

  localparam int TO_W = (WRAP_TO > 1) ? $clog2(WRAP_TO) : 1;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(WRAP_TO - 1);
  localparam logic [IDX_W:0]   DEPTH_L = (IDX_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, WAIT_WRAP} state_t;

  state_t               state;
  logic [7:0]           ram [DEPTH];
  logic [IDX_W:0]       len_reg;
  logic [DWELL_W-1:0]   dwell_reg;
  logic [DWELL_W-1:0]   dwell_cnt;
  logic                 loop_reg;
  logic [TO_W-1:0]      to_cnt;

  logic [IDX_W:0]       len_clamp;
  logic [DWELL_W-1:0]   dwell_eff;
  logic                 last_entry;
  logic                 dwell_done;
  logic                 wrap_go;
  logic                 advance;

  // Advance is decided in the same cycle the dwell (or the wrap wait) finishes,
  // so LOAD follows immediately without a separate ADVANCE state.
  always_comb begin
    len_clamp  = (seq_len > DEPTH_L) ? DEPTH_L : seq_len;
    dwell_eff  = (dwell == '0) ? DWELL_W'(1) : dwell;
    last_entry = ({1'b0, entry_idx} == (len_reg - (IDX_W + 1)'(1)));
    dwell_done = (state == RUN) && (dwell_cnt == '0);
    wrap_go    = (state == WAIT_WRAP) && (phase_wrap || (to_cnt == TO_LAST));
    advance    = (SYNC_SWITCH != 0) ? wrap_go : dwell_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      s0           <= '0;
      s1           <= '0;
      s2           <= '0;
      busy         <= 1'b0;
      entry_idx    <= '0;
      switch_pulse <= 1'b0;
      done         <= 1'b0;
      len_reg      <= '0;
      dwell_reg    <= '0;
      dwell_cnt    <= '0;
      loop_reg     <= 1'b0;
      to_cnt       <= '0;
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else begin
      switch_pulse <= 1'b0;
      done         <= 1'b0;

      // Manual passthrough and playlist edits are only live while idle.
      if (state == IDLE) begin
        s0 <= man_s0;
        s1 <= man_s1;
        s2 <= man_s2;
        if (cfg_we) ram[cfg_addr] <= cfg_data;
      end

      if (stop) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && (seq_len != '0)) begin
              state     <= LOAD;
              busy      <= 1'b1;
              entry_idx <= '0;
              len_reg   <= len_clamp;
              dwell_reg <= dwell_eff;
              loop_reg  <= loop_en;
            end
          end
          LOAD: begin
            {s0, s1, s2} <= ram[entry_idx];
            switch_pulse <= 1'b1;
            dwell_cnt    <= dwell_reg - DWELL_W'(1);
            state        <= RUN;
          end
          RUN: begin
            if (dwell_cnt != '0) begin
              dwell_cnt <= dwell_cnt - DWELL_W'(1);
            end else if (SYNC_SWITCH != 0) begin
              state  <= WAIT_WRAP;
              to_cnt <= '0;
            end
          end
          WAIT_WRAP: begin
            if (!wrap_go) to_cnt <= to_cnt + TO_W'(1);
          end
          default: state <= IDLE;
        endcase

        if (advance) begin
          if (!last_entry) begin
            entry_idx <= entry_idx + IDX_W'(1);
            state     <= LOAD;
          end else if (loop_reg) begin
            entry_idx <= '0;
            state     <= LOAD;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wave_sequence_ctrl.sv
// Bench for wave_sequence_ctrl: three instances (immediate switch, wrap-aligned, short wrap timeout)
// checked with a manual-mode vector table and a per-instance switch scoreboard.
module tb_wave_sequence_ctrl;

  localparam int N = 3;
  localparam int SYNC_P [N] = '{0, 1, 1};
  localparam int WRAP_P [N] = '{16, 1024, 16};
  localparam int WRAP_PERIOD = 37;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] man_s0 = '0;
  logic [2:0] man_s1 = '0;
  logic [1:0] man_s2 = '0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  logic [3:0] seq_len = '0;
  logic [23:0] dwell = '0;
  logic       loop_en = 1'b0;
  logic       phase_wrap = 1'b0;
  logic [N-1:0] start_v = '0;
  logic [N-1:0] stop_v = '0;

  logic [2:0] s0_o [N];
  logic [2:0] s1_o [N];
  logic [1:0] s2_o [N];
  logic       busy_o [N];
  logic [2:0] idx_o [N];
  logic       sp_o [N];
  logic       done_o [N];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    wave_sequence_ctrl #(
      .DEPTH(8), .IDX_W(3), .DWELL_W(24),
      .WRAP_TO(WRAP_P[gi]), .SYNC_SWITCH(SYNC_P[gi])
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .man_s0(man_s0), .man_s1(man_s1), .man_s2(man_s2),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .seq_len(seq_len), .dwell(dwell), .loop_en(loop_en),
      .start(start_v[gi]), .stop(stop_v[gi]), .phase_wrap(phase_wrap),
      .s0(s0_o[gi]), .s1(s1_o[gi]), .s2(s2_o[gi]),
      .busy(busy_o[gi]), .entry_idx(idx_o[gi]),
      .switch_pulse(sp_o[gi]), .done(done_o[gi])
    );
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit wrap_en = 1'b0;
  int last_wrap_cyc = -1000;

  // mode 0: switch must land on cyc; mode 1: switch must land 2 cycles after a phase_wrap
  typedef struct {
    int idx;
    int data;
    int cyc;
    int mode;
  } sb_t;

  sb_t sbq [N][$];
  int  ram_m [N][8];
  int  done_cnt [N];
  int  done_cyc [N];
  int  done_gap [N];

  typedef struct {
    logic [2:0] m0;
    logic [2:0] m1;
    logic [1:0] m2;
    int         exp_s;
  } vec_t;

  vec_t vt [5];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      if (wrap_en && (cyc % WRAP_PERIOD == 0)) begin
        phase_wrap = 1'b1;
        last_wrap_cyc = cyc;
      end else begin
        phase_wrap = 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_mon
    initial begin
      sb_t e;
      done_cnt[gi] = 0;
      done_cyc[gi] = 0;
      done_gap[gi] = 0;
      forever begin
        @(negedge clk);
        if (rst_n && sp_o[gi]) begin
          if (sbq[gi].size() == 0) begin
            check($sformatf("unexpected_switch_u%0d", gi), 1, 0);
          end else begin
            e = sbq[gi].pop_front();
            check($sformatf("sw_idx_u%0d", gi), int'(idx_o[gi]), e.idx);
            check($sformatf("sw_data_u%0d", gi), int'({s0_o[gi], s1_o[gi], s2_o[gi]}), e.data);
            if (e.mode == 0) check($sformatf("sw_cycle_u%0d", gi), cyc, e.cyc);
            else             check($sformatf("sw_wrap_gap_u%0d", gi), cyc - last_wrap_cyc, 2);
          end
        end
        if (rst_n && done_o[gi]) begin
          done_cnt[gi]++;
          done_cyc[gi] = cyc;
          done_gap[gi] = cyc - last_wrap_cyc;
        end
      end
    end
  end

  task automatic write_entry(input int addr, input int data, input int accept_mask);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = addr[2:0];
    cfg_data = data[7:0];
    for (int i = 0; i < N; i++) if (accept_mask[i]) ram_m[i][addr] = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Pushes the expected switches for one playlist run, then pulses start.
  // k is the cycle number of the clock edge that samples start.
  task automatic launch(input int inst, input int len, input int dw, input bit lp,
                        input int nsw, output int k);
    sb_t e;
    int eff_len, eff_dw, step;
    eff_len = (len > 8) ? 8 : len;
    eff_dw  = (dw == 0) ? 1 : dw;
    step    = (inst == 2) ? (1 + eff_dw + WRAP_P[2]) : (1 + eff_dw);
    @(negedge clk);
    k = cyc + 1;
    for (int i = 0; i < nsw; i++) begin
      e.idx  = (eff_len == 0) ? 0 : (i % eff_len);
      e.data = ram_m[inst][e.idx];
      e.cyc  = k + 1 + step * i;
      e.mode = (i > 0 && inst == 1) ? 1 : 0;
      sbq[inst].push_back(e);
    end
    seq_len = len[3:0];
    dwell = dw[23:0];
    loop_en = lp;
    start_v[inst] = 1'b1;
    @(negedge clk);
    start_v[inst] = 1'b0;
  endtask

  task automatic wait_idle(input int inst, input int budget);
    int n;
    n = 0;
    while ((sbq[inst].size() != 0 || busy_o[inst]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("idle_wait_u%0d", inst), int'(n < budget), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, d0;
    int init_data [8];
    init_data = '{8'h4D, 8'hB2, 8'h27, 8'hE9, 8'h71, 8'h9C, 8'h36, 8'hD8};
    vt[0] = '{3'd2, 3'd1, 2'd3, 8'b010_001_11};
    vt[1] = '{3'd0, 3'd0, 2'd0, 8'h00};
    vt[2] = '{3'd7, 3'd7, 2'd3, 8'hFF};
    vt[3] = '{3'd5, 3'd2, 2'd1, 8'b101_010_01};
    vt[4] = '{3'd3, 3'd6, 2'd0, 8'b011_110_00};
    for (int i = 0; i < N; i++) for (int j = 0; j < 8; j++) ram_m[i][j] = 0;

    // Reset values hold even with nonzero manual inputs
    man_s0 = 3'd5; man_s1 = 3'd6; man_s2 = 2'd1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++)
      check($sformatf("reset_outputs_u%0d", i),
            int'({s0_o[i], s1_o[i], s2_o[i], busy_o[i], idx_o[i], sp_o[i], done_o[i]}), 0);
    rst_n = 1'b1;

    // Manual passthrough, one cycle of latency
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      man_s0 = vt[v].m0; man_s1 = vt[v].m1; man_s2 = vt[v].m2;
      @(negedge clk);
      for (int i = 0; i < N; i++)
        check($sformatf("manual_vec%0d_u%0d", v, i), int'({s0_o[i], s1_o[i], s2_o[i]}), vt[v].exp_s);
      check($sformatf("manual_busy%0d", v), int'(busy_o[0]), 0);
    end

    for (int a = 0; a < 8; a++) write_entry(a, init_data[a], 7);

    // Immediate switching: 3 entries every 5 cycles, then done
    d0 = done_cnt[0];
    launch(0, 3, 4, 1'b0, 3, k);
    wait_idle(0, 100);
    check("async_done_count", done_cnt[0] - d0, 1);
    check("async_done_cycle", done_cyc[0], k + 15);
    @(negedge clk);
    check("async_back_to_manual", int'({s0_o[0], s1_o[0], s2_o[0]}), vt[4].exp_s);

    // Wrap-aligned switching
    wrap_en = 1'b1;
    d0 = done_cnt[1];
    launch(1, 3, 10, 1'b0, 3, k);
    wait_idle(1, 400);
    check("sync_done_count", done_cnt[1] - d0, 1);
    check("sync_done_after_wrap", done_gap[1], 1);
    wrap_en = 1'b0;

    // No wraps at all: forced advance after the timeout
    d0 = done_cnt[2];
    launch(2, 2, 3, 1'b0, 2, k);
    wait_idle(2, 200);
    check("timeout_done_count", done_cnt[2] - d0, 1);
    check("timeout_done_cycle", done_cyc[2], k + 40);

    // Looping playlist, stopped mid-RUN
    @(negedge clk);
    man_s0 = 3'd6; man_s1 = 3'd3; man_s2 = 2'd1;
    d0 = done_cnt[0];
    launch(0, 2, 2, 1'b1, 5, k);
    repeat (14) @(negedge clk);
    stop_v[0] = 1'b1;
    @(negedge clk);
    stop_v[0] = 1'b0;
    check("stop_busy_low", int'(busy_o[0]), 0);
    check("stop_all_loops_seen", sbq[0].size(), 0);
    @(negedge clk);
    check("stop_manual_restored", int'({s0_o[0], s1_o[0], s2_o[0]}), 8'b110_011_01);
    repeat (8) @(negedge clk);
    check("stop_no_done", done_cnt[0] - d0, 0);
    check("stop_stays_idle", int'(busy_o[0]), 0);

    // start and stop together: stop wins
    seq_len = 4'd2; dwell = 24'd2;
    start_v[0] = 1'b1; stop_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0; stop_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("start_stop_same_cycle", int'(busy_o[0]), 0);

    // seq_len = 0 is ignored
    launch(0, 0, 3, 1'b0, 0, k);
    repeat (3) @(negedge clk);
    check("len0_not_busy", int'(busy_o[0]), 0);

    // seq_len = 12 clamps to 8; a write during the run must not land in instance 0
    d0 = done_cnt[0];
    launch(0, 12, 1, 1'b0, 8, k);
    write_entry(3, 8'h5A, 6);
    wait_idle(0, 100);
    check("clamp_done_count", done_cnt[0] - d0, 1);
    check("clamp_done_cycle", done_cyc[0], k + 16);

    // dwell = 0 behaves as 1
    launch(0, 2, 0, 1'b0, 2, k);
    wait_idle(0, 50);
    check("dwell0_done_cycle", done_cyc[0], k + 4);

    // Reset mid-playlist clears outputs and the playlist
    launch(0, 3, 5, 1'b0, 3, k);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs",
          int'({s0_o[0], s1_o[0], s2_o[0], busy_o[0], idx_o[0], sp_o[0], done_o[0]}), 0);
    sbq[0].delete();
    for (int i = 0; i < N; i++) for (int j = 0; j < 8; j++) ram_m[i][j] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    launch(0, 1, 1, 1'b0, 1, k);
    wait_idle(0, 50);
    check("after_reset_done_cycle", done_cyc[0], k + 2);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
